// File: rtl/ncl_pkg.sv
// Shared types and helpers for the synchronous-to-NCL transmit stage:
// FSM state encoding, the dual-rail pair type and the per-bit rail encoder.
package ncl_pkg;

   typedef enum logic [1:0] {
      NULL_WAIT = 2'd0,
      IDLE      = 2'd1,
      DATA_WAIT = 2'd2
   } ncl_state_e;

   typedef struct packed {
      logic t;
      logic f;
   } dr_pair_t;

   localparam dr_pair_t DR_NULL = 2'b00;

   // Inversion on a dual-rail bit is just a rail swap, folded in here.
   function automatic dr_pair_t dr_encode(input logic b, input logic inv);
      dr_pair_t p;
      p.t = b ^ inv;
      p.f = ~(b ^ inv);
      return p;
   endfunction

endpackage

// File: rtl/ncl_tx_fifo.sv
// Registered word FIFO feeding the NCL transmit stage; pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module ncl_tx_fifo
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned LW     = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]  wrPtr_q, wrPtr_d;
   logic [ADDR_W:0]  rdPtr_q, rdPtr_d;
   logic             pushEn;
   logic             popEn;

   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[ADDR_W] != rdPtr_q[ADDR_W]) &&
                    (wrPtr_q[ADDR_W-1:0] == rdPtr_q[ADDR_W-1:0]);

   // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
   assign pushEn  = push_i && !full_o;
   assign popEn   = pop_i && !empty_o;

   assign head_o  = mem_q[rdPtr_q[ADDR_W-1:0]];
   assign level_o = LW'(wrPtr_q - rdPtr_q);

   assign wrPtr_d = pushEn ? wrPtr_q + 1'b1 : wrPtr_q;
   assign rdPtr_d = popEn  ? rdPtr_q + 1'b1 : rdPtr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (pushEn) begin
         mem_q[wrPtr_q[ADDR_W-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/ncl_dr_tx_stage.sv
// Synchronous-to-NCL transmit stage: buffers words and emits them as
// flop-driven dual-rail DATA/NULL wavefronts under the 4-phase ki handshake.
// Optional handshake watchdog is built when NCL_TX_TIMEOUT_EN is defined.
module ncl_dr_tx_stage
   import ncl_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      DEPTH       = 4,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] INV_MASK    = '0,
   parameter int               TIMEOUT     = 256
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic [WIDTH-1:0]           dr_t,
   output logic [WIDTH-1:0]           dr_f,
   input  logic                       ki,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       busy,
   output logic                       err_timeout
);

   ncl_state_e             state_q;
   logic [SYNC_STAGES-1:0] kiSync_q;
   logic                   kiS;
   logic [WIDTH-1:0]       drT_q, drF_q;
   logic [WIDTH-1:0]       encT, encF;
   logic [WIDTH-1:0]       fifoHead;
   logic                   fifoFull, fifoEmpty;
   logic                   fifoPop;
   dr_pair_t               pair;

   assign in_ready = rst_n && !fifoFull;
   assign fifoPop  = (state_q == DATA_WAIT) && !kiS;
   assign busy     = rst_n && (!fifoEmpty || (state_q != IDLE));
   assign dr_t     = drT_q;
   assign dr_f     = drF_q;

   ncl_tx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (in_valid),
      .data_i  (in_data),
      .pop_i   (fifoPop),
      .head_o  (fifoHead),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .level_o (level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kiSync_q <= '0;
      end else begin
         kiSync_q <= {kiSync_q[SYNC_STAGES-2:0], ki};
      end
   end

   assign kiS = kiSync_q[SYNC_STAGES-1];

   always_comb begin
      encT = '0;
      encF = '0;
      pair = DR_NULL;
      for (int i = 0; i < WIDTH; i++) begin
         pair    = dr_encode(fifoHead[i], INV_MASK[i]);
         encT[i] = pair.t;
         encF[i] = pair.f;
      end
   end

   // Rails are only rewritten on state entry, so each wavefront is monotonic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= NULL_WAIT;
         drT_q   <= {WIDTH{DR_NULL.t}};
         drF_q   <= {WIDTH{DR_NULL.f}};
      end else begin
         case (state_q)
            NULL_WAIT: begin
               if (kiS) begin
                  state_q <= IDLE;
               end
            end
            IDLE: begin
               if (!fifoEmpty) begin
                  state_q <= DATA_WAIT;
                  drT_q   <= encT;
                  drF_q   <= encF;
               end
            end
            DATA_WAIT: begin
               if (!kiS) begin
                  state_q <= NULL_WAIT;
                  drT_q   <= {WIDTH{DR_NULL.t}};
                  drF_q   <= {WIDTH{DR_NULL.f}};
               end
            end
            default: begin
               state_q <= NULL_WAIT;
               drT_q   <= {WIDTH{DR_NULL.t}};
               drF_q   <= {WIDTH{DR_NULL.f}};
            end
         endcase
      end
   end

`ifdef NCL_TX_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT+1);

   logic [CW-1:0] wdCnt_q;
   logic          err_q;
   logic          stateAdvance;
   logic          waiting;

   assign waiting      = (state_q == DATA_WAIT) || (state_q == NULL_WAIT);
   assign stateAdvance = ((state_q == NULL_WAIT) &&  kiS) ||
                         ((state_q == IDLE)      && !fifoEmpty) ||
                         ((state_q == DATA_WAIT) && !kiS);

   // Watchdog only flags a stalled handshake; it never forces the FSM onward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdCnt_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (stateAdvance) begin
            wdCnt_q <= '0;
         end else if (waiting && (wdCnt_q != CW'(TIMEOUT))) begin
            wdCnt_q <= wdCnt_q + 1'b1;
         end
         if (waiting && !stateAdvance && (wdCnt_q == CW'(TIMEOUT-1))) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_timeout = err_q;
`else
   // With the watchdog compiled out the flag is constant low; TIMEOUT is never negative.
   assign err_timeout = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_ncl_dr_tx_stage.sv
// Directed bench for ncl_dr_tx_stage: two instances share stimulus, one with
// no inversion and one with INV_MASK=8'h0F. Timeout phase adapts to NCL_TX_TIMEOUT_EN.
module tb_ncl_dr_tx_stage;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       ki;
   logic       in_ready,  in_readyI;
   logic [7:0] dr_t,      dr_f;
   logic [7:0] dr_tI,     dr_fI;
   logic [2:0] level,     levelI;
   logic       busy,      busyI;
   logic       err,       errI;

   int checkCount;
   int errCount;
   int waited;
   logic [7:0] words [4];

`ifdef NCL_TX_TIMEOUT_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   ncl_dr_tx_stage #(
      .WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .INV_MASK(8'h00), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .dr_t(dr_t), .dr_f(dr_f), .ki(ki), .level(level),
      .busy(busy), .err_timeout(err)
   );

   ncl_dr_tx_stage #(
      .WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .INV_MASK(8'h0F), .TIMEOUT(16)
   ) dutInv (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_readyI),
      .in_data(in_data), .dr_t(dr_tI), .dr_f(dr_fI), .ki(ki), .level(levelI),
      .busy(busyI), .err_timeout(errI)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] data);
      in_valid = 1'b1;
      in_data  = data;
      tick();
      in_valid = 1'b0;
   endtask

   // Waits for a DATA (wantData=1) or NULL wavefront on the plain instance.
   task automatic waitRails(input string tag, input bit wantData, input int budget,
                            output int ticks);
      bit seen;
      seen  = 0;
      ticks = 0;
      while (!seen && ticks < budget) begin
         tick();
         ticks++;
         if (wantData) seen = ((dr_t | dr_f) != 8'h00);
         else          seen = ((dr_t | dr_f) == 8'h00);
      end
      if (!seen) checkOutput({tag, "_expired"}, 32'd0, 32'd1);
   endtask

   // Both rails high is an illegal NCL code on either instance.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("no_both_high", {16'd0, dr_t & dr_f, dr_tI & dr_fI}, 32'd0);
      end
   end

   initial begin
      checkCount = 0;
      errCount   = 0;
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      ki       = 1'b0;

      tick();
      tick();
      checkOutput("rst_dr_t",     dr_t,     8'h00);
      checkOutput("rst_dr_f",     dr_f,     8'h00);
      checkOutput("rst_level",    level,    3'd0);
      checkOutput("rst_in_ready", in_ready, 1'b0);
      checkOutput("rst_busy",     busy,     1'b0);
      checkOutput("rst_err",      err,      1'b0);
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_ready", in_ready, 1'b1);

      // Single word, plus the rail-swap view on the masked instance.
      ki = 1'b1;
      repeat (4) tick();
      checkOutput("idle_busy", busy, 1'b0);
      applyStimulus(8'h3C);
      checkOutput("latency_null", dr_t, 8'h00);
      checkOutput("latency_level", level, 3'd1);
      tick();
      checkOutput("single_dr_t", dr_t, 8'h3C);
      checkOutput("single_dr_f", dr_f, 8'hC3);
      checkOutput("inv_dr_t",    dr_tI, 8'h33);
      checkOutput("inv_dr_f",    dr_fI, 8'hCC);
      checkOutput("single_busy", busy, 1'b1);
      ki = 1'b0;
      waitRails("single_null", 1'b0, 8, waited);
      checkOutput("single_ack_cycles", waited, 3);
      checkOutput("single_level0", level, 3'd0);

      // Reset asserted while a DATA wavefront is on the rails.
      ki = 1'b1;
      repeat (4) tick();
      applyStimulus(8'hA5);
      tick();
      checkOutput("mid_data_dr_t", dr_t, 8'hA5);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_dr_t", dr_t, 8'h00);
      checkOutput("async_rst_dr_f", dr_f, 8'h00);
      checkOutput("async_rst_level", level, 3'd0);
      ki = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("rel_err", err, 1'b0);
      checkOutput("rel_level", level, 3'd0);

      // Back-pressure: ki held low, five pushes into four entries.
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_data = (k < 4) ? words[k] : 8'h55;
         checkOutput($sformatf("bp_ready_%0d", k), in_ready, (k < 4) ? 1'b1 : 1'b0);
         tick();
      end
      in_valid = 1'b0;
      checkOutput("bp_level", level, 3'd4);
      checkOutput("bp_ready_full", in_ready, 1'b0);
      checkOutput("bp_null_held", dr_t | dr_f, 8'h00);
      for (int k = 0; k < 4; k++) begin
         ki = 1'b1;
         waitRails($sformatf("bp_data_%0d", k), 1'b1, 10, waited);
         checkOutput($sformatf("bp_word_%0d", k), dr_t, words[k]);
         checkOutput($sformatf("bp_word_inv_%0d", k), dr_tI, words[k] ^ 8'h0F);
         ki = 1'b0;
         waitRails($sformatf("bp_null_%0d", k), 1'b0, 10, waited);
      end
      checkOutput("bp_drained", level, 3'd0);
      ki = 1'b1;
      repeat (10) tick();
      checkOutput("bp_no_dup", dr_t | dr_f, 8'h00);
      checkOutput("bp_idle_busy", busy, 1'b0);

      // Sub-cycle ki glitches must never reach the FSM.
      applyStimulus(8'h3C);
      tick();
      checkOutput("stale_data", dr_t, 8'h3C);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #2 ki = 1'b0;
         #3 ki = 1'b1;
      end
      tick();
      checkOutput("stale_held_t", dr_t, 8'h3C);
      checkOutput("stale_held_f", dr_f, 8'hC3);
      ki = 1'b0;
      waitRails("stale_null", 1'b0, 8, waited);
      checkOutput("stale_ack_cycles", waited, 3);

      // Stalled DATA phase: watchdog flag when built in, otherwise stays low.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      ki    = 1'b1;
      repeat (4) tick();
      checkOutput("wd_err_start", err, 1'b0);
      applyStimulus(8'h5A);
      tick();
      repeat (20) tick();
      checkOutput("wd_err_stall", err, EXP_ERR);
      checkOutput("wd_data_held", dr_t, 8'h5A);
      ki = 1'b0;
      waitRails("wd_null", 1'b0, 8, waited);
      checkOutput("wd_err_sticky", err, EXP_ERR);
      checkOutput("wd_level", level, 3'd0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
